// File: rtl/lsu_mem_if.sv
// lsu_mem_if: load/store unit between the decoded control word and a
// word-wide data memory with a req/ack handshake.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   req_valid/req_ready      core request handshake (ready only while idle)
//   req_write, req_width     MemWrite and DataWidth from the decoder
//   req_addr, req_wdata      byte address, right-justified store data
//   rsp_valid/err/rdata      one-cycle completion pulse with extended load data
//   mem_req/we/addr/be/wdata memory access, held stable until mem_ack
//   mem_ack, mem_rdata       memory completion and read word
//
// Word-crossing accesses become two back-to-back word accesses (lo word
// first) when MISALIGN_SPLIT=1; otherwise they complete with rsp_err.
module lsu_mem_if #(
    parameter int ADDR_WIDTH     = 32,
    parameter bit MISALIGN_SPLIT = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_width,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_err,
    output logic [31:0]           rsp_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-3:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ack,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    state_t      state;
    logic        write_q;
    logic [2:0]  width_q;
    logic [1:0]  off_q;
    logic        split_q;
    logic [3:0]  be_hi;
    logic [31:0] wdata_hi;
    logic [31:0] lo_q;

    logic [1:0]  req_off;
    logic [2:0]  req_size;
    logic [3:0]  req_mask;
    logic [7:0]  req_lanes;
    logic [63:0] req_data64;
    logic        req_split;

    // Shift the two-word window down to the access offset, keep the access
    // size and extend. width[2] selects zero extension.
    function automatic logic [31:0] extend_load(input logic [63:0] raw,
                                                input logic [1:0]  off,
                                                input logic [2:0]  width);
        logic [63:0] sh;
        sh = raw >> {off, 3'b000};
        case (width[1:0])
            2'b01:   extend_load = width[2] ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            2'b10:   extend_load = width[2] ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            default: extend_load = sh[31:0];
        endcase
    endfunction

    always_comb begin
        req_off = req_addr[1:0];
        case (req_width[1:0])
            2'b01:   begin req_size = 3'd2; req_mask = 4'b0011; end
            2'b10:   begin req_size = 3'd1; req_mask = 4'b0001; end
            default: begin req_size = 3'd4; req_mask = 4'b1111; end
        endcase
        req_lanes  = {4'b0000, req_mask} << req_off;
        req_data64 = {32'h0, req_wdata} << {req_off, 3'b000};
        req_split  = ({2'b00, req_off} + {1'b0, req_size}) > 4'd4;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'h0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 4'b0000;
            mem_wdata <= 32'h0;
            write_q   <= 1'b0;
            width_q   <= 3'b000;
            off_q     <= 2'b00;
            split_q   <= 1'b0;
            be_hi     <= 4'b0000;
            wdata_hi  <= 32'h0;
            lo_q      <= 32'h0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        write_q   <= req_write;
                        width_q   <= req_width;
                        off_q     <= req_off;
                        split_q   <= req_split;
                        be_hi     <= req_lanes[7:4];
                        wdata_hi  <= req_data64[63:32];
                        req_ready <= 1'b0;
                        rsp_rdata <= 32'h0;
                        if (req_split && !MISALIGN_SPLIT) begin
                            // Rejected without touching memory.
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= req_write;
                            mem_addr  <= req_addr[ADDR_WIDTH-1:2];
                            mem_be    <= req_lanes[3:0];
                            mem_wdata <= req_data64[31:0];
                            state     <= ACC0;
                        end
                    end
                end
                ACC0: begin
                    if (mem_ack) begin
                        lo_q <= mem_rdata;
                        if (split_q) begin
                            // mem_req stays high; the second word follows directly.
                            mem_addr  <= mem_addr + {{(ADDR_WIDTH-3){1'b0}}, 1'b1};
                            mem_be    <= be_hi;
                            mem_wdata <= wdata_hi;
                            state     <= ACC1;
                        end else begin
                            mem_req   <= 1'b0;
                            mem_we    <= 1'b0;
                            mem_be    <= 4'b0000;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= write_q ? 32'h0
                                       : extend_load({32'h0, mem_rdata}, off_q, width_q);
                            state     <= RESP;
                        end
                    end
                end
                ACC1: begin
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_be    <= 4'b0000;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= write_q ? 32'h0
                                   : extend_load({mem_rdata, lo_q}, off_q, width_q);
                        state     <= RESP;
                    end
                end
                default: begin
                    // RESP: the completion pulse is on the outputs this cycle.
                    rsp_err   <= 1'b0;
                    rsp_rdata <= 32'h0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
